// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between instruction-fetch and load/store ports
// Optional round-robin on simultaneous requests: define ARB_FAIRNESS_EN (default: LS wins).
module mem_bus_arbiter #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic        ls_rw,
   input  logic [1:0]  ls_size,
   output logic        ls_ack,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic        mem_sel,
   output logic [31:0] mem_addr,
   output logic        mem_rw,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_wdata,
   output logic        mem_wdata_oe,
   input  logic [31:0] mem_rdata,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t      state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic        gnt_ls, gnt_ls_d;
   logic        ill, ill_d;
   logic        accept, done, pick_ls, ls_ill;
   logic        if_ack_d, ls_ack_d, ls_err_d, sel_d, rw_d, oe_d, busy_d;
   logic [1:0]  size_d;
   logic [31:0] addr_d, wdata_d, if_rdata_d, ls_rdata_d;
`ifdef ARB_FAIRNESS_EN
   logic        last_gnt;
   assign pick_ls = ls_req && (!if_req || !last_gnt);
   // remember which port won the latest accept (1 = LS) so dual requests alternate
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_gnt <= 1'b0;
      else if (accept) last_gnt <= pick_ls;
`else
   assign pick_ls = ls_req;
`endif
   assign ls_ill = ls_size == 2'd3;
   // state, countdown and latched grant information
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         gnt_ls <= 1'b0;
         ill    <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         gnt_ls <= gnt_ls_d;
         ill    <= ill_d;
      end
   // next state: accept only from IDLE, sample when the countdown reaches one
   always_comb begin
      accept   = state == IDLE && (if_req || ls_req);
      done     = state == BUSY && cnt == 4'd1;
      state_d  = accept ? BUSY : done ? RESP : state == RESP ? IDLE : state;
      cnt_d    = accept ? 4'(MEM_LATENCY) : state == BUSY ? cnt - 4'd1 : cnt;
      gnt_ls_d = accept ? pick_ls : gnt_ls;
      ill_d    = accept ? pick_ls && ls_ill : ill;
   end
   // next output values; bus fields latch at accept and hold afterwards
   always_comb begin
      sel_d      = accept ? 1'b1 : done ? 1'b0 : mem_sel;
      addr_d     = accept ? (pick_ls ? ls_addr : if_addr) : mem_addr;
      rw_d       = accept ? pick_ls && ls_rw && !ls_ill : mem_rw;
      size_d     = accept ? (pick_ls && !ls_ill ? ls_size : 2'd2) : mem_size;
      wdata_d    = accept && pick_ls ? ls_wdata : mem_wdata;
      oe_d       = accept ? pick_ls && ls_rw && !ls_ill : done ? 1'b0 : mem_wdata_oe;
      if_ack_d   = done && !gnt_ls;
      ls_ack_d   = done && gnt_ls;
      ls_err_d   = done && gnt_ls && ill;
      if_rdata_d = done && !gnt_ls ? mem_rdata : if_rdata;
      ls_rdata_d = done && gnt_ls && !mem_rw && !ill ? mem_rdata : ls_rdata;
      busy_d     = state_d != IDLE;
   end
   // registered outputs
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         if_ack       <= 1'b0;
         if_rdata     <= 32'd0;
         ls_ack       <= 1'b0;
         ls_rdata     <= 32'd0;
         ls_err       <= 1'b0;
         mem_sel      <= 1'b0;
         mem_addr     <= 32'd0;
         mem_rw       <= 1'b0;
         mem_size     <= 2'd0;
         mem_wdata    <= 32'd0;
         mem_wdata_oe <= 1'b0;
         busy         <= 1'b0;
      end else begin
         if_ack       <= if_ack_d;
         if_rdata     <= if_rdata_d;
         ls_ack       <= ls_ack_d;
         ls_rdata     <= ls_rdata_d;
         ls_err       <= ls_err_d;
         mem_sel      <= sel_d;
         mem_addr     <= addr_d;
         mem_rw       <= rw_d;
         mem_size     <= size_d;
         mem_wdata    <= wdata_d;
         mem_wdata_oe <= oe_d;
         busy         <= busy_d;
      end
endmodule
